vreg_wr_sched: RTL and testbench

//  Write-port scheduler and hazard scoreboard for the 8-entry x 256-bit vector register file.
//  - Shares the register file's single write port between the vector ALU and the load unit (LSU).
//  - Tracks which destinations have in-flight producers, so decode can stall on read-after-write hazards.
//  - Sits between the issue/execute stages and the register file write port.

---
 rtl/vreg_pkg.sv | 13 +
 rtl/vreg_wr_sched_if.sv | 26 ++
 rtl/vreg_wr_sched_rr_arb2.sv | 33 +++
 rtl/vreg_wr_sched.sv | 106 ++++++++++
 tb/tb_vreg_wr_sched.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/vreg_pkg.sv
// Shared constants and types for the vector register file write scheduler.
package vreg_pkg;

  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int DW    = 256;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/vreg_wr_sched_if.sv
// Write-request buses from ALU and LSU plus the register file write port.
interface vreg_wr_if;
  import vreg_pkg::*;

  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_dst;
  logic [DW-1:0] alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_dst;
  logic [DW-1:0] lsu_data;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_dst;
  logic [DW-1:0] rf_wr_data;

  modport master (
    output alu_valid, alu_dst, alu_data, lsu_valid, lsu_dst, lsu_data,
    input  alu_ready, lsu_ready, rf_wr_en, rf_wr_dst, rf_wr_data
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data, lsu_valid, lsu_dst, lsu_data,
    output alu_ready, lsu_ready, rf_wr_en, rf_wr_dst, rf_wr_data
  );
endinterface

// File: rtl/vreg_wr_sched_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the ALU, bit 1 the LSU.
module rr_arb2
  import vreg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_e ptr_reg, ptr_next;

  always_ff @(posedge clk) begin
    if (rst) ptr_reg <= REQ_ALU;
    else     ptr_reg <= ptr_next;
  end

  // The pointer only rotates when both sides asked in the same cycle.
  always_comb begin
    gnt      = req;
    ptr_next = ptr_reg;
    if (req == 2'b11) begin
      if (ptr_reg == REQ_ALU) begin
        gnt      = 2'b01;
        ptr_next = REQ_LSU;
      end else begin
        gnt      = 2'b10;
        ptr_next = REQ_ALU;
      end
    end
  end

endmodule

// File: rtl/vreg_wr_sched.sv
// Write-port scheduler and RAW hazard scoreboard for the vector register file.
// Optional forwarding from the committing write is enabled by VREG_WR_BYPASS_EN.
module vreg_wr_sched
  import vreg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  vreg_wr_if.slave         bus,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_dst,
  input  logic [AW-1:0]    rd_addr_1,
  input  logic [AW-1:0]    rd_addr_2,
  output logic             stall_1,
  output logic             stall_2,
  output logic [NREGS-1:0] pending,
  output logic             sb_err
`ifdef VREG_WR_BYPASS_EN
  ,
  output logic             fwd_1,
  output logic             fwd_2,
  output logic [DW-1:0]    fwd_data
`endif
);

  logic [1:0]       gnt;
  logic             alu_acc, lsu_acc;
  logic             wr_en_reg;
  logic [AW-1:0]    wr_dst_reg;
  logic [DW-1:0]    wr_data_reg;
  logic [NREGS-1:0] pending_reg, pending_next;
  logic             err_reg, err_set;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.lsu_valid, bus.alu_valid}),
    .gnt (gnt)
  );

  assign bus.alu_ready = gnt[0];
  assign bus.lsu_ready = gnt[1];
  assign alu_acc       = bus.alu_valid & gnt[0];
  assign lsu_acc       = bus.lsu_valid & gnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_reg   <= 1'b0;
      wr_dst_reg  <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= alu_acc | lsu_acc;
      if (alu_acc) begin
        wr_dst_reg  <= bus.alu_dst;
        wr_data_reg <= bus.alu_data;
      end else if (lsu_acc) begin
        wr_dst_reg  <= bus.lsu_dst;
        wr_data_reg <= bus.lsu_data;
      end
    end
  end

  assign bus.rf_wr_en   = wr_en_reg;
  assign bus.rf_wr_dst  = wr_dst_reg;
  assign bus.rf_wr_data = wr_data_reg;

  // A set in the same cycle as the clear means a new producer, so set wins.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_sb
      logic set_bit, clr_bit;
      assign set_bit          = sb_set && (sb_dst == AW'(gi));
      assign clr_bit          = wr_en_reg && (wr_dst_reg == AW'(gi));
      assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
    end
  endgenerate

  assign err_set = (sb_set && pending_reg[sb_dst] &&
                    !(wr_en_reg && (wr_dst_reg == sb_dst)))
                 || (wr_en_reg && !pending_reg[wr_dst_reg]);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      err_reg     <= err_reg | err_set;
    end
  end

  assign pending = pending_reg;
  assign sb_err  = err_reg;

`ifdef VREG_WR_BYPASS_EN
  // Forward only when the committing value is not immediately superseded.
  assign fwd_1    = wr_en_reg && (wr_dst_reg == rd_addr_1) && !(sb_set && (sb_dst == rd_addr_1));
  assign fwd_2    = wr_en_reg && (wr_dst_reg == rd_addr_2) && !(sb_set && (sb_dst == rd_addr_2));
  assign fwd_data = wr_data_reg;
  assign stall_1  = pending_reg[rd_addr_1] & ~fwd_1;
  assign stall_2  = pending_reg[rd_addr_2] & ~fwd_2;
`else
  assign stall_1  = pending_reg[rd_addr_1];
  assign stall_2  = pending_reg[rd_addr_2];
`endif

endmodule

// File: tb/tb_vreg_wr_sched.sv
// Directed bench for vreg_wr_sched: arbitration, write latency, scoreboard, errors, reset.
module tb_vreg_wr_sched;
  import vreg_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             sb_set;
  logic [AW-1:0]    sb_dst, rd_addr_1, rd_addr_2;
  logic             stall_1, stall_2, sb_err;
  logic [NREGS-1:0] pending;
`ifdef VREG_WR_BYPASS_EN
  logic             fwd_1, fwd_2;
  logic [DW-1:0]    fwd_data;
`endif

  int tests = 0;
  int fails = 0;

  vreg_wr_if bus ();

  vreg_wr_sched dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sb_set    (sb_set),
    .sb_dst    (sb_dst),
    .rd_addr_1 (rd_addr_1),
    .rd_addr_2 (rd_addr_2),
    .stall_1   (stall_1),
    .stall_2   (stall_2),
    .pending   (pending),
    .sb_err    (sb_err)
`ifdef VREG_WR_BYPASS_EN
    ,
    .fwd_1     (fwd_1),
    .fwd_2     (fwd_2),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    sb_set = 1'b0; sb_dst = '0; rd_addr_1 = '0; rd_addr_2 = '0;
    bus.alu_valid = 1'b0; bus.alu_dst = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_dst = '0; bus.lsu_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pending", 256'(pending), 256'(8'h00));
    chk("rst_wr_en",   256'(bus.rf_wr_en), 256'(1'b0));
    chk("rst_wr_dst",  256'(bus.rf_wr_dst), 256'(3'd0));
    chk("rst_wr_data", bus.rf_wr_data, 256'd0);
    chk("rst_err",     256'(sb_err), 256'(1'b0));

    // 1: single ALU write to v3
    sb_set = 1'b1; sb_dst = 3'd3;
    tick();
    sb_set = 1'b0;
    chk("t1_pending_set", 256'(pending), 256'(8'h08));
    bus.alu_valid = 1'b1; bus.alu_dst = 3'd3; bus.alu_data = 256'hA1;
    #1;
    chk("t1_alu_ready", 256'(bus.alu_ready), 256'(1'b1));
    chk("t1_lsu_ready", 256'(bus.lsu_ready), 256'(1'b0));
    tick();
    bus.alu_valid = 1'b0;
    chk("t1_wr_en",   256'(bus.rf_wr_en), 256'(1'b1));
    chk("t1_wr_dst",  256'(bus.rf_wr_dst), 256'(3'd3));
    chk("t1_wr_data", bus.rf_wr_data, 256'hA1);
    chk("t1_pend_held", 256'(pending), 256'(8'h08));
    tick();
    chk("t1_wr_pulse", 256'(bus.rf_wr_en), 256'(1'b0));
    chk("t1_pend_clr", 256'(pending), 256'(8'h00));

    // 2: contended ALU(v1)/LSU(v2), pointer starts at ALU
    sb_set = 1'b1; sb_dst = 3'd1; tick();
    sb_dst = 3'd2; tick();
    sb_set = 1'b0;
    chk("t2_pending", 256'(pending), 256'(8'h06));
    bus.alu_valid = 1'b1; bus.alu_dst = 3'd1; bus.alu_data = 256'hB1;
    bus.lsu_valid = 1'b1; bus.lsu_dst = 3'd2; bus.lsu_data = 256'hB2;
    #1;
    chk("t2_c1_alu_ready", 256'(bus.alu_ready), 256'(1'b1));
    chk("t2_c1_lsu_ready", 256'(bus.lsu_ready), 256'(1'b0));
    tick();
    bus.alu_valid = 1'b0;
    #1;
    chk("t2_c2_lsu_ready", 256'(bus.lsu_ready), 256'(1'b1));
    chk("t2_c2_wr_dst", 256'(bus.rf_wr_dst), 256'(3'd1));
    chk("t2_c2_wr_data", bus.rf_wr_data, 256'hB1);
    tick();
    bus.lsu_valid = 1'b0;
    chk("t2_c3_wr_en",   256'(bus.rf_wr_en), 256'(1'b1));
    chk("t2_c3_wr_dst",  256'(bus.rf_wr_dst), 256'(3'd2));
    chk("t2_c3_wr_data", bus.rf_wr_data, 256'hB2);
    chk("t2_c3_pending", 256'(pending), 256'(8'h04));
    tick();
    chk("t2_c4_pending", 256'(pending), 256'(8'h00));
    // pointer now at LSU: next conflict goes to LSU, the one after to ALU
    sb_set = 1'b1; sb_dst = 3'd4; tick();
    sb_dst = 3'd7; tick();
    sb_set = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dst = 3'd4; bus.alu_data = 256'hC4;
    bus.lsu_valid = 1'b1; bus.lsu_dst = 3'd7; bus.lsu_data = 256'hC7;
    #1;
    chk("t2_c5_lsu_ready", 256'(bus.lsu_ready), 256'(1'b1));
    chk("t2_c5_alu_ready", 256'(bus.alu_ready), 256'(1'b0));
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    chk("t2_c6_alu_ready", 256'(bus.alu_ready), 256'(1'b1));
    tick();
    bus.alu_valid = 1'b0;
    chk("t2_c7_wr_dst", 256'(bus.rf_wr_dst), 256'(3'd4));
    bus.alu_valid = 1'b1; bus.lsu_valid = 1'b1;
    #1;
    chk("t2_c7_alu_ready", 256'(bus.alu_ready), 256'(1'b1));
    chk("t2_c7_lsu_ready", 256'(bus.lsu_ready), 256'(1'b0));
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
    tick();
    chk("t2_pending_end", 256'(pending), 256'(8'h00));
    chk("t2_err", 256'(sb_err), 256'(1'b0));

    // 3: hazard on v5
    sb_set = 1'b1; sb_dst = 3'd5; tick();
    sb_set = 1'b0;
    rd_addr_1 = 3'd5; rd_addr_2 = 3'd4;
    #1;
    chk("t3_stall_1", 256'(stall_1), 256'(1'b1));
    chk("t3_stall_2", 256'(stall_2), 256'(1'b0));
    bus.alu_valid = 1'b1; bus.alu_dst = 3'd5; bus.alu_data = 256'hD5;
    tick();
    bus.alu_valid = 1'b0;
    #1;
`ifdef VREG_WR_BYPASS_EN
    chk("t3_commit_stall_1", 256'(stall_1), 256'(1'b0));
    chk("t3_fwd_1", 256'(fwd_1), 256'(1'b1));
    chk("t3_fwd_2", 256'(fwd_2), 256'(1'b0));
    chk("t3_fwd_data", fwd_data, 256'hD5);
`else
    chk("t3_commit_stall_1", 256'(stall_1), 256'(1'b1));
`endif
    chk("t3_commit_stall_2", 256'(stall_2), 256'(1'b0));
    tick();
    chk("t3_after_stall_1", 256'(stall_1), 256'(1'b0));

    // 4: re-set v6 while it commits
    sb_set = 1'b1; sb_dst = 3'd6; tick();
    sb_set = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dst = 3'd6; bus.alu_data = 256'hE6;
    tick();
    bus.alu_valid = 1'b0;
    sb_set = 1'b1; sb_dst = 3'd6;
    tick();
    sb_set = 1'b0;
    chk("t4_pending6", 256'(pending[6]), 256'(1'b1));
    chk("t4_err", 256'(sb_err), 256'(1'b0));
    bus.alu_valid = 1'b1; tick();
    bus.alu_valid = 1'b0; tick();
    chk("t4_pending_clr", 256'(pending), 256'(8'h00));
    chk("t4_err_after", 256'(sb_err), 256'(1'b0));

    // 5: double set of v0 is a protocol error and sticks
    sb_set = 1'b1; sb_dst = 3'd0; tick();
    tick();
    sb_set = 1'b0;
    chk("t5_err", 256'(sb_err), 256'(1'b1));
    tick(); tick();
    chk("t5_err_sticky", 256'(sb_err), 256'(1'b1));

    // 6: reset right after a contended accept (pointer moves to LSU)
    sb_set = 1'b1; sb_dst = 3'd2; tick();
    sb_set = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dst = 3'd2; bus.alu_data = 256'hF2;
    bus.lsu_valid = 1'b1; bus.lsu_dst = 3'd3; bus.lsu_data = 256'hF3;
    #1;
    chk("t6_alu_ready", 256'(bus.alu_ready), 256'(1'b1));
    tick();
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
    rst = 1'b1;
    chk("t6_inflight", 256'(bus.rf_wr_en), 256'(1'b1));
    tick();
    rst = 1'b0;
    chk("t6_wr_en",   256'(bus.rf_wr_en), 256'(1'b0));
    chk("t6_pending", 256'(pending), 256'(8'h00));
    chk("t6_err",     256'(sb_err), 256'(1'b0));
    bus.alu_valid = 1'b1; bus.lsu_valid = 1'b1;
    #1;
    chk("t6_ptr_alu", 256'(bus.alu_ready), 256'(1'b1));
    chk("t6_ptr_lsu", 256'(bus.lsu_ready), 256'(1'b0));
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
